// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fully-connected layer, N_OUT saturating MACs in parallel over N_IN pixels,
// followed by a sequential argmax and optional ReLU on the published scores.
module fc_layer_engine #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter int W_W    = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10,
  localparam int CID_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [DATA_W-1:0]      image,
  input  logic [N_OUT*W_W-1:0]   wdata,
  output logic [ADDR_W-1:0]      counter1,
  output logic                   busy,
  output logic                   done,
  output logic [N_OUT*ACC_W-1:0] result,
  output logic [CID_W-1:0]       class_id
);
  localparam int P_W = DATA_W + W_W;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_MAC    = 3'd2;
  localparam logic [2:0] S_ARGMAX = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic signed [P_W:0] L_MAX = (P_W+1)'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
  localparam logic signed [P_W:0] L_MIN = ~L_MAX;

  logic [2:0]                r_state;
  logic                      r_relu;
  logic [ADDR_W-1:0]         r_cnt;
  logic [CID_W-1:0]          r_best;
  logic [CID_W-1:0]          r_idx;
  logic [N_OUT*ACC_W-1:0]    r_result;
  logic [CID_W-1:0]          r_cls;
  logic signed [ACC_W-1:0]   r_acc [N_OUT];
  logic signed [ACC_W-1:0]   w_acc_nxt [N_OUT];
  logic signed [ACC_W-1:0]   w_fin [N_OUT];
  logic [2:0]                w_nxt;
  logic [CID_W-1:0]          w_best_nxt;
  logic                      w_last_mac;
  logic                      w_last_arg;

  for (genvar k = 0; k < N_OUT; k++) begin : g_mac
    logic signed [P_W-1:0] w_prod;
    logic signed [P_W:0]   w_sum;
    assign w_prod = $signed(image) * $signed(wdata[k*W_W +: W_W]);
    assign w_sum = $signed({w_prod[P_W-1], w_prod}) +
                   $signed({{(P_W+1-ACC_W){r_acc[k][ACC_W-1]}}, r_acc[k]});
    assign w_acc_nxt[k] = (w_sum > L_MAX) ? L_MAX[ACC_W-1:0] :
                          (w_sum < L_MIN) ? L_MIN[ACC_W-1:0] : w_sum[ACC_W-1:0];
    // with a single class there is no argmax phase, so results come straight from the last MAC
    assign w_fin[k] = (N_OUT == 1) ? w_acc_nxt[k] : r_acc[k];
  end

  assign w_last_mac = r_cnt == ADDR_W'(N_IN - 1);
  assign w_last_arg = r_idx == CID_W'(N_OUT - 1);
  assign w_best_nxt = (r_acc[r_idx] > r_acc[r_best]) ? r_idx : r_best;
  assign w_nxt = (r_state == S_IDLE)   ? (start ? S_CLEAR : S_IDLE) :
                 (r_state == S_CLEAR)  ? S_MAC :
                 (r_state == S_MAC)    ? (w_last_mac ? ((N_OUT == 1) ? S_DONE : S_ARGMAX) : S_MAC) :
                 (r_state == S_ARGMAX) ? (w_last_arg ? S_DONE : S_ARGMAX) : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_relu   <= 1'b0;
      r_cnt    <= '0;
      r_best   <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_cls    <= '0;
      for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && start) r_relu <= relu_en;
      if (r_state == S_CLEAR) begin
        r_cnt  <= '0;
        r_best <= '0;
        r_idx  <= CID_W'(1);
        for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
      end
      if (r_state == S_MAC) begin
        r_cnt <= w_last_mac ? '0 : r_cnt + ADDR_W'(1);
        for (int k = 0; k < N_OUT; k++) r_acc[k] <= w_acc_nxt[k];
      end
      if (r_state == S_ARGMAX) begin
        r_best <= w_best_nxt;
        r_idx  <= r_idx + CID_W'(1);
      end
      if (w_nxt == S_DONE) begin
        r_cls <= (N_OUT == 1) ? '0 : w_best_nxt;
        for (int k = 0; k < N_OUT; k++)
          r_result[k*ACC_W +: ACC_W] <= (r_relu && w_fin[k][ACC_W-1]) ? '0 : w_fin[k];
      end
    end
  end

  assign counter1 = r_cnt;
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_DONE;
  assign result   = r_result;
  assign class_id = r_cls;
endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: scoreboard bench; expected scores come from a plain-arithmetic layer model
// queued at each accepted start and checked by a monitor whenever done is seen.
module tb_fc_layer_engine;
  localparam int N_IN = 784, N_OUT = 10, DATA_W = 32, W_W = 16, ACC_W = 32, ADDR_W = 10;
  localparam int LAT = N_IN + N_OUT;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct packed {
    logic [N_OUT*ACC_W-1:0] res;
    logic [3:0]             cls;
    int                     n;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic [DATA_W-1:0]      image;
  logic [N_OUT*W_W-1:0]   wdata;
  logic [ADDR_W-1:0]      counter1;
  logic                   busy, done;
  logic [N_OUT*ACC_W-1:0] result;
  logic [3:0]             class_id;

  longint img [N_IN];
  longint wts [N_IN][N_OUT];
  int     w_a;
  exp_t   q[$];
  int     n_cmp = 0, n_err = 0;
  bit     held = 1'b0;

  fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .W_W(W_W),
                    .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .image(image),
    .wdata(wdata), .counter1(counter1), .busy(busy), .done(done), .result(result),
    .class_id(class_id));

  always #5 clk = ~clk;

  assign w_a   = (int'(counter1) < N_IN) ? int'(counter1) : 0;
  assign image = DATA_W'(img[w_a]);
  always_comb begin
    wdata = '0;
    for (int k = 0; k < N_OUT; k++) wdata[k*W_W +: W_W] = W_W'(wts[w_a][k]);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit relu, input int n);
    longint acc [N_OUT];
    exp_t   e;
    int     best = 0;
    for (int k = 0; k < N_OUT; k++) acc[k] = 0;
    for (int i = 0; i < N_IN; i++)
      for (int k = 0; k < N_OUT; k++) begin
        acc[k] = acc[k] + img[i] * wts[i][k];
        acc[k] = (acc[k] > MAXV) ? MAXV : (acc[k] < MINV) ? MINV : acc[k];
      end
    for (int k = 1; k < N_OUT; k++) if (acc[k] > acc[best]) best = k;
    e.res = '0;
    for (int k = 0; k < N_OUT; k++)
      e.res[k*ACC_W +: ACC_W] = (relu && acc[k] < 0) ? '0 : ACC_W'(acc[k]);
    e.cls = 4'(best);
    e.n   = n;
    return e;
  endfunction

  task automatic monitor();
    int cyc = 0, last_done = -1, sweep_err = 0, m;
    logic [N_OUT*ACC_W-1:0] last_res = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        last_res  = '0;
        last_done = -1;
        sweep_err = 0;
      end else begin
        cyc++;
        if (q.size() > 0) begin
          m = cyc - q[0].n - 1;
          if (busy !== 1'b1 || int'(counter1) != ((m >= 1 && m <= N_IN) ? m - 1 : 0)) sweep_err++;
        end
        if (done) begin
          chk("done_has_pending_run", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < N_OUT; k++)
              chk($sformatf("result[%0d]", k), $signed(result[k*ACC_W +: ACC_W]),
                  $signed(e.res[k*ACC_W +: ACC_W]));
            chk("class_id", class_id, e.cls);
            // detection happens one negedge before the accepting edge
            chk("latency", cyc - e.n, LAT + 1);
            chk("counter1_busy_sweep_errors", sweep_err, 0);
          end
          if (held && last_done >= 0) chk("done_spacing", cyc - last_done, LAT + 2);
          sweep_err = 0;
          last_done = cyc;
          last_res  = result;
        end else begin
          n_cmp++;
          if (result !== last_res) begin
            n_err++;
            $display("FAIL result_hold: got %h, expected %h", result, last_res);
          end
        end
        if (start && !busy) q.push_back(model(relu_en, cyc));
      end
    end
  endtask

  task automatic fill(input longint px, input longint wd, input int cls, input longint wc);
    for (int i = 0; i < N_IN; i++) begin
      img[i] = px;
      for (int k = 0; k < N_OUT; k++) wts[i][k] = (k == cls) ? wc : wd;
    end
  endtask

  task automatic fill_rand();
    logic [15:0] t;
    for (int i = 0; i < N_IN; i++) begin
      img[i] = ($urandom_range(3) == 0) ? longint'($signed($urandom())) :
               longint'($urandom_range(200)) - 100;
      for (int k = 0; k < N_OUT; k++) begin
        t = 16'($urandom());
        wts[i][k] = ($urandom_range(1) == 0) ? longint'($signed(t)) :
                    longint'($urandom_range(20)) - 10;
      end
    end
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < LAT + 20 && !got; i++) begin
      @(posedge clk); #1;
      got = done;
    end
    chk("done_seen", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic run(input bit relu);
    relu_en = relu;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    relu_en = ~relu_en;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
  endtask

  initial begin
    fork monitor(); join_none
    fill(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_busy", busy, 0);
    chk("in_reset_result_nonzero", |result, 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_result_nonzero", |result, 0);
    chk("idle_class_id", class_id, 0);
    chk("idle_counter1", counter1, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    fill(1, 0, 3, 2);
    run(1'b0);
    fill(5, -1, 7, -1);
    run(1'b1);
    run(1'b0);
    fill(MAXV, 32767, 1, -32768);
    run(1'b0);
    run(1'b1);
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run(1'($urandom_range(1)));
    end

    fill(3, 1, 4, 7);
    relu_en = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    wait_done();
    held = 1'b1;
    wait_done();
    wait_done();
    start = 1'b0;
    held  = 1'b0;

    fill(1, 0, 3, 2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 1000 && counter1 != 10'd400; i++) begin
      @(posedge clk); #1;
    end
    chk("reached_counter1_400", counter1, 400);
    #2 reset = 1'b0;
    #1;
    chk("abort_result_nonzero", |result, 0);
    chk("abort_class_id", class_id, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_counter1", counter1, 0);
    @(posedge clk); #1 reset = 1'b1;
    run(1'b0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
